fpsu_alt_sched: RTL and testbench
=================================

FPSU_ALT_SCHED -- requirements
Module: fpsu_alt_sched

Interface
REQ-001 Parameter WIDTH, default 68, alternate-data word width (one SIMD half).
REQ-002 Parameter TAGW, default 4, completion tag width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 src0_vld  input  1  source 0 offers a word.
REQ-006 src0_data  input  WIDTH  source 0 word.
REQ-007 src0_tag  input  TAGW  source 0 tag.
REQ-008 src0_rdy  output  1  source 0 FIFO can accept.
REQ-009 src1_vld, src1_data, src1_tag, src1_rdy  same as REQ-005..008, source 1.
REQ-010 slot_busy  input  1  FP store lane occupied this cycle; no injection may be granted.
REQ-011 flush  input  1  discard all queued and in-flight work.
REQ-012 ALT_INP  output  2  one-hot injection select to the FP store unit; bit n selects ALTDATAn.
REQ-013 ALTDATA0, ALTDATA1  output  WIDTH each  injected words for source 0 / 1.
REQ-014 done_en  output  1  completion pulse.
REQ-015 done_src  output  1  source of completed word.
REQ-016 done_tag  output  TAGW  tag of completed word.

Function
REQ-017 Each source SHALL own a 2-entry FIFO (data+tag); srcN_rdy SHALL be 1 iff that FIFO holds <2 entries, derived from registered count only.
REQ-018 Push SHALL occur on srcN_vld & srcN_rdy; a vld with rdy=0 SHALL be ignored; order within a source SHALL be preserved.
REQ-019 Grant condition per cycle: slot_busy=0, flush=0, at least one FIFO non-empty.
REQ-020 Arbitration SHALL be round-robin via a last-grant pointer; after reset source 0 wins the first contention; a lone requester wins regardless of pointer; pointer updates only on a grant.
REQ-021 On grant, the FIFO head SHALL pop in that cycle; push and pop on the same FIFO in the same cycle SHALL leave count unchanged.
REQ-022 Latency: ALT_INP SHALL be registered, asserting the granted bit for exactly one cycle, the cycle after the grant; 2'b00 otherwise; never 2'b11.
REQ-023 ALTDATAn SHALL load the popped word in the same edge as its ALT_INP bit and SHALL hold its value otherwise.
REQ-024 Minimum grant-to-ALT_INP latency from an empty FIFO: vld in cycle T, push at edge T, grant in T+1, ALT_INP in T+2.
REQ-025 Back-to-back grants SHALL be possible every cycle while slot_busy=0 (one grant per cycle maximum).
REQ-026 A 2-stage completion pipe SHALL carry {src,tag}; done_en SHALL pulse exactly 2 cycles after the corresponding ALT_INP cycle, with matching done_src/done_tag.
REQ-027 flush=1 SHALL, at the next edge, empty both FIFOs, clear ALT_INP to 2'b00 and kill both completion-pipe stages (no done_en for in-flight work); flush SHALL win over simultaneous push and grant; pointer and ALTDATA SHALL be unaffected.
REQ-028 slot_busy SHALL only block new grants; already-registered ALT_INP and completion stages SHALL proceed.

Reset
REQ-029 rst=0 SHALL asynchronously clear: FIFO counts/pointers, ALT_INP=2'b00, done_en=0, done_src=0, done_tag=0, ALTDATA0=ALTDATA1=0, last-grant pointer=source 1; srcN_rdy=1 while in reset.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight words with no done_en; first grant after release follows REQ-020.

Verification
REQ-031 Single word: src0 pushes data 68'h1234, tag 5, slot_busy=0 -> ALT_INP=2'b01 two cycles later, ALTDATA0=68'h1234; done_en=1, src=0, tag=5 two cycles after that.
REQ-032 Contention: both FIFOs hold 2 entries (tags 1,2 / 9,10) from reset -> ALT_INP sequence 01,10,01,10 on consecutive cycles; done tags 1,9,2,10.
REQ-033 Backpressure: slot_busy=1, src1 pushes 3 words -> src1_rdy=0 after 2 pushes, third ignored; slot_busy release -> exactly 2 injections.
REQ-034 Flush: 1 word in ALT_INP cycle, 1 queued, flush pulse -> no done_en for either, ALT_INP=00, both rdy=1 next cycle.
REQ-035 Async reset mid-stream: rst=0 between edges -> outputs zero immediately without clock; after release, src0 wins first contention.
REQ-036 Random: constrained-random vld/slot_busy/flush against a reference queue model; check order, no ALT_INP=11, no lost or duplicated tags.

Source files
------------

// File: rtl/fpsu_alt_sched_if.sv
// Handshake/bus bundle between the two alternate-data sources, the FP store
// lane control and the alternate-data scheduler.
interface fpsu_alt_sched_if #(
    parameter int WIDTH = 68,
    parameter int TAGW  = 4
);
    logic             src0_vld;
    logic [WIDTH-1:0] src0_data;
    logic [TAGW-1:0]  src0_tag;
    logic             src0_rdy;
    logic             src1_vld;
    logic [WIDTH-1:0] src1_data;
    logic [TAGW-1:0]  src1_tag;
    logic             src1_rdy;
    logic             slot_busy;
    logic             flush;
    logic [1:0]       ALT_INP;
    logic [WIDTH-1:0] ALTDATA0;
    logic [WIDTH-1:0] ALTDATA1;
    logic             done_en;
    logic             done_src;
    logic [TAGW-1:0]  done_tag;

    modport master (
        output src0_vld, src0_data, src0_tag, input src0_rdy,
        output src1_vld, src1_data, src1_tag, input src1_rdy,
        output slot_busy, flush,
        input  ALT_INP, ALTDATA0, ALTDATA1, done_en, done_src, done_tag
    );

    modport slave (
        input  src0_vld, src0_data, src0_tag, output src0_rdy,
        input  src1_vld, src1_data, src1_tag, output src1_rdy,
        input  slot_busy, flush,
        output ALT_INP, ALTDATA0, ALTDATA1, done_en, done_src, done_tag
    );
endinterface

// File: rtl/fpsu_alt_sched.sv
// Alternate-data scheduler: two 2-deep source FIFOs, round-robin injection
// into the FP store lane, and a 2-stage completion pipe reporting {src,tag}.
module fpsu_alt_sched #(
    parameter int WIDTH = 68,
    parameter int TAGW  = 4
) (
    input logic            clk,
    input logic            rst,
    fpsu_alt_sched_if.slave bus
);

    logic [1:0]       vld_s;
    logic [1:0]       rdy_s;
    logic [1:0]       push_s;
    logic [1:0]       req_s;
    logic [1:0]       gnt_s;
    logic [WIDTH-1:0] in_data_s   [2];
    logic [TAGW-1:0]  in_tag_s    [2];
    logic [WIDTH-1:0] head_data_s [2];
    logic [TAGW-1:0]  head_tag_s  [2];

    logic [WIDTH-1:0] fifo_data_r [2][2];
    logic [TAGW-1:0]  fifo_tag_r  [2][2];
    logic [1:0]       count_r     [2];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic             last_r;

    logic [1:0]       alt_inp_r;
    logic [WIDTH-1:0] alt_data_r  [2];
    logic             alt_src_r;
    logic [TAGW-1:0]  alt_tag_r;
    logic             s1_vld_r;
    logic             s1_src_r;
    logic [TAGW-1:0]  s1_tag_r;
    logic             done_en_r;
    logic             done_src_r;
    logic [TAGW-1:0]  done_tag_r;

    // last == 1 means source 1 was granted last, so source 0 now has priority
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] pick;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

    assign vld_s        = {bus.src1_vld, bus.src0_vld};
    assign in_data_s[0] = bus.src0_data;
    assign in_data_s[1] = bus.src1_data;
    assign in_tag_s[0]  = bus.src0_tag;
    assign in_tag_s[1]  = bus.src1_tag;

    // Per-source ready/request derived from registered occupancy, plus FIFO heads
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            rdy_s[n]       = (count_r[n] != 2'd2);
            req_s[n]       = (count_r[n] != 2'd0);
            head_data_s[n] = fifo_data_r[n][rd_ptr_r[n]];
            head_tag_s[n]  = fifo_tag_r[n][rd_ptr_r[n]];
        end
        push_s = vld_s & rdy_s;
    end

    // Grant selection; a granted head pops in the same cycle
    always_comb begin
        if (!bus.slot_busy && !bus.flush) begin
            gnt_s = rr_pick(req_s, last_r);
        end else begin
            gnt_s = 2'b00;
        end
    end

    // FIFO occupancy and read/write pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                count_r[n] <= 2'd0;
            end
            wr_ptr_r <= 2'b00;
            rd_ptr_r <= 2'b00;
        end else if (bus.flush) begin
            for (int n = 0; n < 2; n++) begin
                count_r[n] <= 2'd0;
            end
            wr_ptr_r <= 2'b00;
            rd_ptr_r <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_s[n] && !gnt_s[n]) begin
                    count_r[n] <= count_r[n] + 2'd1;
                end else if (!push_s[n] && gnt_s[n]) begin
                    count_r[n] <= count_r[n] - 2'd1;
                end else begin
                    count_r[n] <= count_r[n];
                end
                if (push_s[n]) begin
                    wr_ptr_r[n] <= ~wr_ptr_r[n];
                end
                if (gnt_s[n]) begin
                    rd_ptr_r[n] <= ~rd_ptr_r[n];
                end
            end
        end
    end

    // FIFO storage; contents behind an empty count are don't-care
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push_s[n]) begin
                fifo_data_r[n][wr_ptr_r[n]] <= in_data_s[n];
                fifo_tag_r[n][wr_ptr_r[n]]  <= in_tag_s[n];
            end
        end
    end

    // Round-robin pointer, moved only by an actual grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= 1'b1;
        end else if (gnt_s != 2'b00) begin
            last_r <= gnt_s[1];
        end
    end

    // Injection select and the {src,tag} travelling with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alt_inp_r <= 2'b00;
            alt_src_r <= 1'b0;
            alt_tag_r <= {TAGW{1'b0}};
        end else if (bus.flush) begin
            alt_inp_r <= 2'b00;
        end else begin
            alt_inp_r <= gnt_s;
            if (gnt_s != 2'b00) begin
                alt_src_r <= gnt_s[1];
                alt_tag_r <= gnt_s[1] ? head_tag_s[1] : head_tag_s[0];
            end
        end
    end

    // Injected data words; held between grants and untouched by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alt_data_r[0] <= {WIDTH{1'b0}};
            alt_data_r[1] <= {WIDTH{1'b0}};
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (gnt_s[n]) begin
                    alt_data_r[n] <= head_data_s[n];
                end
            end
        end
    end

    // Completion pipe: stage 1 follows ALT_INP, done follows stage 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_r   <= 1'b0;
            s1_src_r   <= 1'b0;
            s1_tag_r   <= {TAGW{1'b0}};
            done_en_r  <= 1'b0;
            done_src_r <= 1'b0;
            done_tag_r <= {TAGW{1'b0}};
        end else if (bus.flush) begin
            s1_vld_r  <= 1'b0;
            done_en_r <= 1'b0;
        end else begin
            s1_vld_r  <= (alt_inp_r != 2'b00);
            s1_src_r  <= alt_src_r;
            s1_tag_r  <= alt_tag_r;
            done_en_r <= s1_vld_r;
            if (s1_vld_r) begin
                done_src_r <= s1_src_r;
                done_tag_r <= s1_tag_r;
            end
        end
    end

    assign bus.src0_rdy = rdy_s[0];
    assign bus.src1_rdy = rdy_s[1];
    assign bus.ALT_INP  = alt_inp_r;
    assign bus.ALTDATA0 = alt_data_r[0];
    assign bus.ALTDATA1 = alt_data_r[1];
    assign bus.done_en  = done_en_r;
    assign bus.done_src = done_src_r;
    assign bus.done_tag = done_tag_r;

endmodule

// File: tb/tb_fpsu_alt_sched.sv
// Directed and model-checked random stimulus for fpsu_alt_sched; inputs are
// driven and outputs sampled 1 time unit after each rising edge.
module tb_fpsu_alt_sched;
    localparam int WIDTH = 68;
    localparam int TAGW  = 4;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    fpsu_alt_sched_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();
    fpsu_alt_sched #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [TAGW-1:0]  t;
    } ent_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src0_vld  = 1'b0;
        bus.src0_data = 68'h0;
        bus.src0_tag  = 4'd0;
        bus.src1_vld  = 1'b0;
        bus.src1_data = 68'h0;
        bus.src1_tag  = 4'd0;
        bus.slot_busy = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #2;
        total_cnt++; if (bus.ALT_INP !== 2'b00) $display("FAIL rst_alt got=%b exp=00", bus.ALT_INP); else pass_cnt++;
        total_cnt++; if (bus.done_en !== 1'b0) $display("FAIL rst_done_en got=%b exp=0", bus.done_en); else pass_cnt++;
        total_cnt++; if (bus.done_src !== 1'b0 || bus.done_tag !== 4'd0) $display("FAIL rst_done_id got=%b/%h exp=0/0", bus.done_src, bus.done_tag); else pass_cnt++;
        total_cnt++; if (bus.ALTDATA0 !== 68'h0 || bus.ALTDATA1 !== 68'h0) $display("FAIL rst_altdata got=%h/%h exp=0/0", bus.ALTDATA0, bus.ALTDATA1); else pass_cnt++;
        total_cnt++; if (bus.src0_rdy !== 1'b1 || bus.src1_rdy !== 1'b1) $display("FAIL rst_rdy got=%b%b exp=11", bus.src1_rdy, bus.src0_rdy); else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.src0_vld  = 1'b1;
        bus.src0_data = 68'h1234;
        bus.src0_tag  = 4'd5;
        step();
        bus.src0_vld = 1'b0;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b01) $display("FAIL single_alt got=%b exp=01", bus.ALT_INP); else pass_cnt++;
        total_cnt++; if (bus.ALTDATA0 !== 68'h1234) $display("FAIL single_data got=%h exp=1234", bus.ALTDATA0); else pass_cnt++;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b00 || bus.done_en !== 1'b0) $display("FAIL single_gap got=%b/%b exp=00/0", bus.ALT_INP, bus.done_en); else pass_cnt++;
        step();
        total_cnt++; if (bus.done_en !== 1'b1 || bus.done_src !== 1'b0 || bus.done_tag !== 4'd5) $display("FAIL single_done got=%b/%b/%h exp=1/0/5", bus.done_en, bus.done_src, bus.done_tag); else pass_cnt++;
        step();
        total_cnt++; if (bus.done_en !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", bus.done_en); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0]       seq   [4];
        logic [TAGW-1:0]  dtags [4];
        logic             dsrc  [4];
        logic [WIDTH-1:0] ddata [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        dtags[0] = 4'd1; dtags[1] = 4'd9; dtags[2] = 4'd2; dtags[3] = 4'd10;
        dsrc[0] = 1'b0; dsrc[1] = 1'b1; dsrc[2] = 1'b0; dsrc[3] = 1'b1;
        ddata[0] = 68'h101; ddata[1] = 68'h109; ddata[2] = 68'h102; ddata[3] = 68'h10A;
        apply_reset();
        bus.slot_busy = 1'b1;
        bus.src0_vld = 1'b1; bus.src0_tag = 4'd1; bus.src0_data = 68'h101;
        bus.src1_vld = 1'b1; bus.src1_tag = 4'd9; bus.src1_data = 68'h109;
        step();
        bus.src0_tag = 4'd2;  bus.src0_data = 68'h102;
        bus.src1_tag = 4'd10; bus.src1_data = 68'h10A;
        step();
        bus.src0_vld = 1'b0;
        bus.src1_vld = 1'b0;
        total_cnt++; if (bus.src0_rdy !== 1'b0 || bus.src1_rdy !== 1'b0) $display("FAIL cont_full_rdy got=%b%b exp=00", bus.src1_rdy, bus.src0_rdy); else pass_cnt++;
        total_cnt++; if (bus.ALT_INP !== 2'b00) $display("FAIL cont_busy_alt got=%b exp=00", bus.ALT_INP); else pass_cnt++;
        bus.slot_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 4) begin
                total_cnt++; if (bus.ALT_INP !== seq[i]) $display("FAIL cont_alt[%0d] got=%b exp=%b", i, bus.ALT_INP, seq[i]); else pass_cnt++;
                total_cnt++;
                if ((seq[i][0] ? bus.ALTDATA0 : bus.ALTDATA1) !== ddata[i])
                    $display("FAIL cont_data[%0d] got=%h exp=%h", i, seq[i][0] ? bus.ALTDATA0 : bus.ALTDATA1, ddata[i]);
                else pass_cnt++;
            end else begin
                total_cnt++; if (bus.ALT_INP !== 2'b00) $display("FAIL cont_alt[%0d] got=%b exp=00", i, bus.ALT_INP); else pass_cnt++;
            end
            if (i >= 2 && i < 6) begin
                total_cnt++;
                if (bus.done_en !== 1'b1 || bus.done_tag !== dtags[i-2] || bus.done_src !== dsrc[i-2])
                    $display("FAIL cont_done[%0d] got=%b/%b/%h exp=1/%b/%h", i, bus.done_en, bus.done_src, bus.done_tag, dsrc[i-2], dtags[i-2]);
                else pass_cnt++;
            end else begin
                total_cnt++; if (bus.done_en !== 1'b0) $display("FAIL cont_done[%0d] got=%b exp=0", i, bus.done_en); else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        int              inj;
        int              ndone;
        int              bad_src;
        logic [TAGW-1:0] got [4];
        inj = 0; ndone = 0; bad_src = 0;
        bus.slot_busy = 1'b1;
        bus.src1_vld = 1'b1; bus.src1_tag = 4'd3; bus.src1_data = 68'h303;
        step();
        bus.src1_tag = 4'd4; bus.src1_data = 68'h304;
        step();
        total_cnt++; if (bus.src1_rdy !== 1'b0) $display("FAIL bp_rdy_full got=%b exp=0", bus.src1_rdy); else pass_cnt++;
        bus.src1_tag = 4'd5; bus.src1_data = 68'h305;
        step();
        total_cnt++; if (bus.src1_rdy !== 1'b0 || bus.ALT_INP !== 2'b00) $display("FAIL bp_hold got=%b/%b exp=0/00", bus.src1_rdy, bus.ALT_INP); else pass_cnt++;
        bus.src1_vld  = 1'b0;
        bus.slot_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.ALT_INP == 2'b10) inj++;
            if (bus.ALT_INP != 2'b10 && bus.ALT_INP != 2'b00) bad_src++;
            if (bus.done_en === 1'b1 && ndone < 4) begin
                got[ndone] = bus.done_tag;
                ndone++;
            end
        end
        total_cnt++; if (inj != 2 || bad_src != 0) $display("FAIL bp_injections got=%0d/%0d exp=2/0", inj, bad_src); else pass_cnt++;
        total_cnt++; if (ndone != 2) $display("FAIL bp_done_count got=%0d exp=2", ndone); else pass_cnt++;
        if (ndone >= 2) begin
            total_cnt++; if (got[0] !== 4'd3 || got[1] !== 4'd4) $display("FAIL bp_done_tags got=%h,%h exp=3,4", got[0], got[1]); else pass_cnt++;
        end
        total_cnt++; if (bus.src1_rdy !== 1'b1) $display("FAIL bp_rdy_end got=%b exp=1", bus.src1_rdy); else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.src0_vld = 1'b1; bus.src0_tag = 4'd6; bus.src0_data = 68'h606;
        bus.src1_vld = 1'b1; bus.src1_tag = 4'd7; bus.src1_data = 68'h707;
        step();
        bus.src0_vld = 1'b0;
        bus.src1_vld = 1'b0;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b01 || bus.ALTDATA0 !== 68'h606) $display("FAIL flush_pre got=%b/%h exp=01/606", bus.ALT_INP, bus.ALTDATA0); else pass_cnt++;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total_cnt++; if (bus.ALT_INP !== 2'b00) $display("FAIL flush_alt got=%b exp=00", bus.ALT_INP); else pass_cnt++;
        total_cnt++; if (bus.src0_rdy !== 1'b1 || bus.src1_rdy !== 1'b1) $display("FAIL flush_rdy got=%b%b exp=11", bus.src1_rdy, bus.src0_rdy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bus.done_en !== 1'b0 || bus.ALT_INP !== 2'b00) $display("FAIL flush_quiet[%0d] got=%b/%b exp=0/00", i, bus.done_en, bus.ALT_INP); else pass_cnt++;
            step();
        end
        total_cnt++; if (bus.ALTDATA0 !== 68'h606 || bus.ALTDATA1 !== 68'h304) $display("FAIL flush_altdata got=%h/%h exp=606/304", bus.ALTDATA0, bus.ALTDATA1); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.src0_vld = 1'b1; bus.src0_tag = 4'd8;  bus.src0_data = 68'h808;
        bus.src1_vld = 1'b1; bus.src1_tag = 4'd11; bus.src1_data = 68'hB0B;
        step();
        bus.src0_vld = 1'b0;
        bus.src1_vld = 1'b0;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b10) $display("FAIL arst_pre got=%b exp=10", bus.ALT_INP); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if (bus.ALT_INP !== 2'b00 || bus.done_en !== 1'b0) $display("FAIL arst_now got=%b/%b exp=00/0", bus.ALT_INP, bus.done_en); else pass_cnt++;
        total_cnt++; if (bus.ALTDATA0 !== 68'h0 || bus.ALTDATA1 !== 68'h0) $display("FAIL arst_data got=%h/%h exp=0/0", bus.ALTDATA0, bus.ALTDATA1); else pass_cnt++;
        total_cnt++; if (bus.src0_rdy !== 1'b1 || bus.src1_rdy !== 1'b1) $display("FAIL arst_rdy got=%b%b exp=11", bus.src1_rdy, bus.src0_rdy); else pass_cnt++;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (bus.done_en !== 1'b0 || bus.ALT_INP !== 2'b00) $display("FAIL arst_quiet[%0d] got=%b/%b exp=0/00", i, bus.done_en, bus.ALT_INP); else pass_cnt++;
        end
        bus.slot_busy = 1'b1;
        bus.src0_vld = 1'b1; bus.src0_tag = 4'd12; bus.src0_data = 68'hC0C;
        bus.src1_vld = 1'b1; bus.src1_tag = 4'd13; bus.src1_data = 68'hD0D;
        step();
        bus.src0_vld  = 1'b0;
        bus.src1_vld  = 1'b0;
        bus.slot_busy = 1'b0;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b01) $display("FAIL arst_first got=%b exp=01", bus.ALT_INP); else pass_cnt++;
        step();
        total_cnt++; if (bus.ALT_INP !== 2'b10) $display("FAIL arst_second got=%b exp=10", bus.ALT_INP); else pass_cnt++;
        step();
        step();
    endtask

    task automatic test_random();
        ent_t             q0[$];
        ent_t             q1[$];
        ent_t             e;
        logic             m_last, m_altsrc, m_s1v, m_s1src, m_den, m_dsrc;
        logic [1:0]       m_alt, g;
        logic [TAGW-1:0]  m_alttag, m_s1tag, m_dtag;
        logic [WIDTH-1:0] m_ad0, m_ad1;
        logic             v0, v1, busy, fl, mr0, mr1;
        logic [95:0]      rnd;
        logic [WIDTH-1:0] d0, d1;
        logic [TAGW-1:0]  t0, t1;
        int               m_done_cnt, dut_done_cnt;
        apply_reset();
        m_last = 1'b1; m_alt = 2'b00; m_altsrc = 1'b0; m_alttag = 4'd0;
        m_s1v = 1'b0; m_s1src = 1'b0; m_s1tag = 4'd0;
        m_den = 1'b0; m_dsrc = 1'b0; m_dtag = 4'd0;
        m_ad0 = 68'h0; m_ad1 = 68'h0;
        t0 = 4'd0; t1 = 4'd8;
        m_done_cnt = 0; dut_done_cnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc < 285) begin
                v0   = ($urandom_range(0, 99) < 60);
                v1   = ($urandom_range(0, 99) < 60);
                busy = ($urandom_range(0, 99) < 25);
                fl   = ($urandom_range(0, 99) < 4);
            end else begin
                v0 = 1'b0; v1 = 1'b0; busy = 1'b0; fl = 1'b0;
            end
            rnd = {$urandom(), $urandom(), $urandom()};
            d0  = rnd[WIDTH-1:0];
            rnd = {$urandom(), $urandom(), $urandom()};
            d1  = rnd[WIDTH-1:0];
            mr0 = (q0.size() < 2);
            mr1 = (q1.size() < 2);
            total_cnt++;
            if ({bus.src1_rdy, bus.src0_rdy} !== {mr1, mr0})
                $display("FAIL rand_rdy[%0d] got=%b%b exp=%b%b", cyc, bus.src1_rdy, bus.src0_rdy, mr1, mr0);
            else pass_cnt++;
            bus.src0_vld = v0; bus.src0_data = d0; bus.src0_tag = t0;
            bus.src1_vld = v1; bus.src1_data = d1; bus.src1_tag = t1;
            bus.slot_busy = busy;
            bus.flush     = fl;
            if (fl) begin
                q0.delete();
                q1.delete();
                m_alt = 2'b00;
                m_s1v = 1'b0;
                m_den = 1'b0;
            end else begin
                m_den = m_s1v;
                if (m_s1v) begin
                    m_dsrc = m_s1src;
                    m_dtag = m_s1tag;
                end
                m_s1v   = (m_alt != 2'b00);
                m_s1src = m_altsrc;
                m_s1tag = m_alttag;
                g = 2'b00;
                if (!busy) begin
                    if (q0.size() > 0 && q1.size() > 0) g = m_last ? 2'b01 : 2'b10;
                    else if (q0.size() > 0) g = 2'b01;
                    else if (q1.size() > 0) g = 2'b10;
                end
                m_alt = g;
                if (g == 2'b01) begin
                    e = q0.pop_front();
                    m_ad0 = e.d; m_alttag = e.t; m_altsrc = 1'b0; m_last = 1'b0;
                end else if (g == 2'b10) begin
                    e = q1.pop_front();
                    m_ad1 = e.d; m_alttag = e.t; m_altsrc = 1'b1; m_last = 1'b1;
                end
                if (v0 && mr0) begin
                    e.d = d0; e.t = t0; q0.push_back(e); t0 = t0 + 4'd1;
                end
                if (v1 && mr1) begin
                    e.d = d1; e.t = t1; q1.push_back(e); t1 = t1 + 4'd1;
                end
            end
            if (m_den) m_done_cnt++;
            step();
            if (bus.done_en === 1'b1) dut_done_cnt++;
            total_cnt++; if (bus.ALT_INP === 2'b11) $display("FAIL rand_alt_11[%0d] got=%b", cyc, bus.ALT_INP); else pass_cnt++;
            total_cnt++; if (bus.ALT_INP !== m_alt) $display("FAIL rand_alt[%0d] got=%b exp=%b", cyc, bus.ALT_INP, m_alt); else pass_cnt++;
            total_cnt++;
            if (bus.ALTDATA0 !== m_ad0 || bus.ALTDATA1 !== m_ad1)
                $display("FAIL rand_data[%0d] got=%h/%h exp=%h/%h", cyc, bus.ALTDATA0, bus.ALTDATA1, m_ad0, m_ad1);
            else pass_cnt++;
            total_cnt++;
            if (bus.done_en !== m_den || bus.done_src !== m_dsrc || bus.done_tag !== m_dtag)
                $display("FAIL rand_done[%0d] got=%b/%b/%h exp=%b/%b/%h", cyc, bus.done_en, bus.done_src, bus.done_tag, m_den, m_dsrc, m_dtag);
            else pass_cnt++;
        end
        bus.flush = 1'b0;
        total_cnt++; if (dut_done_cnt != m_done_cnt) $display("FAIL rand_done_total got=%0d exp=%0d", dut_done_cnt, m_done_cnt); else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
